// File: rtl/equilibrium_pkg.sv
// equilibrium_pkg -- shared definitions for the stepper position controller.
//   state_e      : controller state encoding (also shown on the debug display)
//   *_DEF        : default parameter values for stepper_pos_ctrl
//   clamp_pos    : limits a requested position to the rightmost legal step
//   step_pos     : one step right/left, saturating at 0 and pos_max
package equilibrium_pkg;

  localparam int          POS_W           = 16;
  localparam int          HALF_PERIOD_DEF = 25000;  // 1 kHz step rate at 50 MHz
  localparam int          DIR_SETUP_DEF   = 50;
  localparam logic [15:0] POS_MAX_DEF     = 16'd4000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HOMING   = 3'd1,
    ST_DIR_WAIT = 3'd2,
    ST_STEP_HI  = 3'd3,
    ST_STEP_LO  = 3'd4
  } state_e;

  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] pos,
                                                 input logic [POS_W-1:0] pos_max);
    return (pos > pos_max) ? pos_max : pos;
  endfunction

  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] pos,
                                                input logic             right,
                                                input logic [POS_W-1:0] pos_max);
    if (right) return (pos >= pos_max) ? pos_max : pos + 16'd1;
    else       return (pos == '0)      ? '0      : pos - 16'd1;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer -- loadable down-counter timing DIR_WAIT and the step phases.
//   clock    in  system clock
//   reset    in  asynchronous active-high reset
//   load     in  load load_val this cycle
//   load_val in  W  cycles-minus-one of the phase being started
//   done     out counter has reached zero (last cycle of the phase)
module phase_timer #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/stepper_pos_ctrl.sv
// stepper_pos_ctrl -- absolute position controller for a step/dir driver.
//   clock, reset            system clock, asynchronous active-high reset
//   calib                   one-cycle homing request (highest priority)
//   trava_servo             while high, no new move starts; a running move
//                           stops after its current step pulse
//   target_pos/target_valid requested absolute position and its strobe
//   end_left, end_right     asynchronous limit switches, active-high
//   step, dir               driver outputs (dir 1 = position increasing)
//   current_pos             position counter in steps
//   busy, homed             status; db_estado shows the state encoding
module stepper_pos_ctrl
  import equilibrium_pkg::*;
#(
  parameter int          HALF_PERIOD = HALF_PERIOD_DEF,
  parameter int          DIR_SETUP   = DIR_SETUP_DEF,
  parameter logic [15:0] POS_MAX     = POS_MAX_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        calib,
  input  logic        trava_servo,
  input  logic [15:0] target_pos,
  input  logic        target_valid,
  input  logic        end_left,
  input  logic        end_right,
  output logic        step,
  output logic        dir,
  output logic [15:0] current_pos,
  output logic        busy,
  output logic        homed,
  output logic [2:0]  db_estado
);

  localparam int TMR_MAX = (HALF_PERIOD > DIR_SETUP) ? HALF_PERIOD : DIR_SETUP;
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(HALF_PERIOD - 1);
  localparam logic [TW-1:0] DIR_LOAD  = TW'(DIR_SETUP - 1);

  state_e      state_q, state_d;
  logic        home_hi_q, home_hi_d;   // high half of a homing step pulse
  logic        step_q, step_d;
  logic        dir_q, dir_d;
  logic [15:0] pos_q, pos_d;
  logic [15:0] target_q, target_d;
  logic        homed_q, homed_d;
  logic [1:0]  el_sync_q, er_sync_q;

  logic        end_left_s, end_right_s;
  logic        accept;
  logic [15:0] tgt_clamped;
  logic        tmr_load, tmr_done;
  logic [TW-1:0] tmr_val;

  assign end_left_s  = el_sync_q[1];
  assign end_right_s = er_sync_q[1];

  phase_timer #(.W(TW)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign tgt_clamped = clamp_pos(target_pos, POS_MAX);
  assign accept      = target_valid && !calib && homed_q && !trava_servo &&
                       (state_q != ST_HOMING);

  always_comb begin
    state_d   = state_q;
    home_hi_d = home_hi_q;
    dir_d     = dir_q;
    pos_d     = pos_q;
    target_d  = accept ? tgt_clamped : target_q;
    homed_d   = homed_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    if (calib) begin
      // Timer loaded with zero so the first HOMING cycle can already look
      // at end_left and finish without ever raising step.
      state_d   = ST_HOMING;
      home_hi_d = 1'b0;
      dir_d     = 1'b0;
      homed_d   = 1'b0;
      tmr_load  = 1'b1;
    end else if (state_q != ST_HOMING && end_left_s && !dir_q) begin
      state_d  = ST_IDLE;
      pos_d    = '0;
      target_d = '0;
    end else if (state_q != ST_HOMING && end_right_s && dir_q) begin
      state_d  = ST_IDLE;
      pos_d    = POS_MAX;
      target_d = POS_MAX;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept && tgt_clamped != pos_q) begin
            dir_d    = (tgt_clamped > pos_q);
            state_d  = ST_DIR_WAIT;
            tmr_load = 1'b1;
            tmr_val  = DIR_LOAD;
          end
        end
        ST_HOMING: begin
          // Position is unknown while homing, so pos_q is left untouched.
          if (end_left_s) begin
            state_d   = ST_IDLE;
            home_hi_d = 1'b0;
            pos_d     = '0;
            homed_d   = 1'b1;
          end else if (tmr_done) begin
            home_hi_d = !home_hi_q;
            tmr_load  = 1'b1;
            tmr_val   = HALF_LOAD;
          end
        end
        ST_DIR_WAIT: begin
          if (tmr_done) begin
            state_d  = ST_STEP_HI;
            pos_d    = step_pos(pos_q, dir_q, POS_MAX);
            tmr_load = 1'b1;
            tmr_val  = HALF_LOAD;
          end
        end
        ST_STEP_HI: begin
          if (tmr_done) begin
            state_d  = ST_STEP_LO;
            tmr_load = 1'b1;
            tmr_val  = HALF_LOAD;
          end
        end
        ST_STEP_LO: begin
          // The only point where a new target, a reversal or the hold input
          // can change the motion, so a pulse is never cut short.
          if (tmr_done) begin
            if (trava_servo || pos_q == target_q) begin
              state_d = ST_IDLE;
            end else if ((target_q > pos_q) == dir_q) begin
              state_d  = ST_STEP_HI;
              pos_d    = step_pos(pos_q, dir_q, POS_MAX);
              tmr_load = 1'b1;
              tmr_val  = HALF_LOAD;
            end else begin
              dir_d    = !dir_q;
              state_d  = ST_DIR_WAIT;
              tmr_load = 1'b1;
              tmr_val  = DIR_LOAD;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Step is registered from the next state so it rises in the same cycle
    // the position counter changes.
    step_d = (state_d == ST_STEP_HI) || (state_d == ST_HOMING && home_hi_d);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      el_sync_q <= '0;
      er_sync_q <= '0;
      state_q   <= ST_IDLE;
      home_hi_q <= 1'b0;
      step_q    <= 1'b0;
      dir_q     <= 1'b0;
      pos_q     <= '0;
      target_q  <= '0;
      homed_q   <= 1'b0;
    end else begin
      el_sync_q <= {el_sync_q[0], end_left};
      er_sync_q <= {er_sync_q[0], end_right};
      state_q   <= state_d;
      home_hi_q <= home_hi_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      pos_q     <= pos_d;
      target_q  <= target_d;
      homed_q   <= homed_d;
    end
  end

  assign step        = step_q;
  assign dir         = dir_q;
  assign current_pos = pos_q;
  assign busy        = (state_q != ST_IDLE);
  assign homed       = homed_q;
  assign db_estado   = state_q;

endmodule

// File: tb/tb_stepper_pos_ctrl.sv
// tb_stepper_pos_ctrl -- directed bench for stepper_pos_ctrl with
// HALF_PERIOD=4, DIR_SETUP=2, POS_MAX=200.
module tb_stepper_pos_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        calib;
  logic        trava_servo;
  logic [15:0] target_pos;
  logic        target_valid;
  logic        end_left;
  logic        end_right;
  logic        step;
  logic        dir;
  logic [15:0] current_pos;
  logic        busy;
  logic        homed;
  logic [2:0]  db_estado;

  int checks = 0;
  int errors = 0;

  logic prev_step = 1'b0;
  logic rose, fell;

  stepper_pos_ctrl #(
    .HALF_PERIOD (4),
    .DIR_SETUP   (2),
    .POS_MAX     (16'd200)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .calib        (calib),
    .trava_servo  (trava_servo),
    .target_pos   (target_pos),
    .target_valid (target_valid),
    .end_left     (end_left),
    .end_right    (end_right),
    .step         (step),
    .dir          (dir),
    .current_pos  (current_pos),
    .busy         (busy),
    .homed        (homed),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
    rose      = step && !prev_step;
    fell      = !step && prev_step;
    prev_step = step;
  endtask

  task automatic pulse_target(input logic [15:0] v);
    target_pos   = v;
    target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
  endtask

  initial begin
    int pulses, p2, hi_len, lo_len, cnt, idle_at, dw, dw_start;
    logic redir;

    reset = 1'b1; calib = 1'b0; trava_servo = 1'b0; target_pos = '0;
    target_valid = 1'b0; end_left = 1'b0; end_right = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_step",  step, 0);
    check("rst_dir",   dir, 0);
    check("rst_pos",   current_pos, 0);
    check("rst_busy",  busy, 0);
    check("rst_homed", homed, 0);
    check("rst_state", db_estado, 0);
    reset = 1'b0;
    tick();

    // Targets are ignored until homed.
    pulse_target(16'd5);
    tick();
    check("unhomed_busy", busy, 0);

    // Homing: three 4/4 pulses, end_left raised after the third one.
    calib = 1'b1; tick(); calib = 1'b0;
    check("home_state", db_estado, 1);
    check("home_dir",   dir, 0);
    pulses = 0; hi_len = 0; lo_len = 0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (rose) begin
        if (pulses > 0) check("home_gap", lo_len, 4);
        pulses++;
        hi_len = 0;
      end
      if (fell) begin
        check("home_width", hi_len, 4);
        lo_len = 0;
        if (pulses == 3) end_left = 1'b1;
      end
      if (step) hi_len++; else lo_len++;
      if (!busy) break;
    end
    check("home_done_busy", busy, 0);
    check("home_pulses",    pulses, 3);
    check("home_pos",       current_pos, 0);
    check("home_homed",     homed, 1);
    end_left = 1'b0;
    repeat (3) tick();

    // Move 0 -> 5: 2-cycle dir wait, 5 pulses, idle 43 edges after strobe.
    pulse_target(16'd5);
    check("mv5_state", db_estado, 2);
    check("mv5_dir",   dir, 1);
    check("mv5_step",  step, 0);
    pulses = 0; idle_at = 0;
    for (int n = 2; n < 200; n++) begin
      tick();
      if (rose) begin
        pulses++;
        check("mv5_pos_at_rise", current_pos, pulses);
      end
      if (!busy) begin
        idle_at = n;
        break;
      end
    end
    check("mv5_idle_at", idle_at, 43);
    check("mv5_pulses",  pulses, 5);
    check("mv5_pos",     current_pos, 5);

    // Move toward 10, retarget to 2 during the 2nd pulse.
    pulse_target(16'd10);
    pulses = 0; p2 = 0; redir = 1'b0; cnt = 0; dw = 0; dw_start = 0;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (redir) cnt++;
      if (rose) begin
        if (redir) begin
          p2++;
          check("rv_pos_at_rise", current_pos, 7 - p2);
        end else begin
          pulses++;
          if (pulses == 2) begin
            check("rv_pos_2nd", current_pos, 7);
            pulse_target(16'd2);
            redir = 1'b1;
            cnt   = 1;
          end
        end
      end
      if (redir && db_estado == 3'd2) begin
        dw++;
        if (dw_start == 0) dw_start = cnt;
      end
      if (!busy) break;
    end
    check("rv_wait_start", dw_start, 8);
    check("rv_wait_len",   dw, 2);
    check("rv_dir",        dir, 0);
    check("rv_pulses",     p2, 5);
    check("rv_pos",        current_pos, 2);
    check("rv_busy",       busy, 0);

    // Target 300 clamps to 200; end_right raised at position 50.
    pulse_target(16'd300);
    cnt = 0; pulses = 0;
    for (int n = 0; n < 1000; n++) begin
      tick();
      if (end_right) begin
        cnt++;
        if (rose) pulses++;
      end
      if (rose && current_pos == 16'd50 && !end_right) end_right = 1'b1;
      if (!busy) break;
    end
    check("er_react", cnt, 3);
    check("er_extra_pulses", pulses, 0);
    check("er_pos",   current_pos, 200);
    check("er_step",  step, 0);
    check("er_state", db_estado, 0);
    end_right = 1'b0;
    repeat (3) tick();
    pulse_target(16'd300);
    check("clamp_state", db_estado, 0);
    repeat (3) tick();
    check("clamp_busy", busy, 0);
    check("clamp_pos",  current_pos, 200);

    // Hold raised during STEP_HI: pulse completes, then IDLE, no more steps.
    pulse_target(16'd195);
    for (int n = 0; n < 50; n++) begin
      tick();
      if (rose) break;
    end
    check("tr_step_hi", step, 1);
    check("tr_pos",     current_pos, 199);
    trava_servo = 1'b1;
    pulse_target(16'd100);
    cnt = 1; pulses = 0;
    for (int n = 0; n < 50; n++) begin
      tick();
      cnt++;
      if (rose) pulses++;
      if (!busy) break;
    end
    check("tr_idle_at", cnt, 8);
    check("tr_pulses",  pulses, 0);
    repeat (4) tick();
    pulse_target(16'd150);
    for (int n = 0; n < 8; n++) begin
      tick();
      if (rose) pulses++;
    end
    check("tr_hold_pulses", pulses, 0);
    check("tr_hold_busy",   busy, 0);
    check("tr_hold_pos",    current_pos, 199);
    trava_servo = 1'b0;

    // Homing with end_left already active: one HOMING cycle, no pulse.
    end_left = 1'b1;
    tick();
    calib = 1'b1; tick(); calib = 1'b0;
    check("fh_state", db_estado, 1);
    check("fh_homed", homed, 0);
    check("fh_step",  step, 0);
    tick();
    check("fh_done_state", db_estado, 0);
    check("fh_done_homed", homed, 1);
    check("fh_done_pos",   current_pos, 0);
    check("fh_done_step",  step, 0);
    end_left = 1'b0;
    repeat (3) tick();

    // Reset mid STEP_HI clears everything without a clock edge.
    pulse_target(16'd10);
    for (int n = 0; n < 50; n++) begin
      tick();
      if (rose) break;
    end
    check("ar_pre_step", step, 1);
    check("ar_pre_pos",  current_pos, 1);
    #2 reset = 1'b1;
    #1;
    check("ar_step",  step, 0);
    check("ar_pos",   current_pos, 0);
    check("ar_homed", homed, 0);
    check("ar_busy",  busy, 0);
    check("ar_dir",   dir, 0);
    #2 reset = 1'b0;
    tick();
    pulse_target(16'd20);
    tick();
    check("ar_unhomed_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stepper_pos_ctrl.md
STEPPER_POS_CTRL -- requirements
Module: stepper_pos_ctrl

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 25000, clocks per step-high and per step-low phase (1 kHz at 50 MHz).
REQ-002 SHALL have parameter DIR_SETUP, default 50, clocks dir is held stable before the first step after any dir change.
REQ-003 SHALL have parameter POS_MAX, default 16'd4000, rightmost legal position in steps.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clock  in  1  system clock, rising edge.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 calib  in  1  one-cycle pulse requesting homing.
REQ-008 trava_servo  in  1  hold level; blocks new moves while high.
REQ-009 target_pos  in  16  requested absolute position in steps.
REQ-010 target_valid  in  1  one-cycle strobe qualifying target_pos.
REQ-011 end_left, end_right  in  1 each  asynchronous limit switches, active-high.
REQ-012 step  out  1  step pulse to driver.
REQ-013 dir  out  1  1 = right (position increasing), 0 = left.
REQ-014 current_pos  out  16  position counter (feeds db_current_pos).
REQ-015 busy  out  1  high in any state except IDLE.
REQ-016 homed  out  1  high once homing has completed.
REQ-017 db_estado  out  3  state encoding for hexa7seg debug.

Function
REQ-018 end_left/end_right SHALL pass through a 2-flop synchronizer; all references below use the synchronized values.
REQ-019 States SHALL be IDLE=0, HOMING=1, DIR_WAIT=2, STEP_HI=3, STEP_LO=4, driven on db_estado.
REQ-020 calib in any state SHALL enter HOMING next cycle with dir=0, homed=0; calib has priority over target_valid.
REQ-021 HOMING SHALL emit steps (HALF_PERIOD high, HALF_PERIOD low) without changing current_pos until end_left=1, then set current_pos=0, homed=1, IDLE.
REQ-022 end_left already 1 on entering HOMING SHALL complete homing in one cycle with no step pulse.
REQ-023 target_valid SHALL be accepted only when homed=1 and trava_servo=0, in any non-HOMING state; otherwise ignored.
REQ-024 An accepted target SHALL be clamped to POS_MAX and stored in an internal target register.
REQ-025 From IDLE, target equal to current_pos SHALL leave the block in IDLE (busy stays 0).
REQ-026 From IDLE, a differing target SHALL set dir=(target>current_pos) and enter DIR_WAIT for exactly DIR_SETUP cycles, step=0.
REQ-027 On entering STEP_HI, step SHALL go 1 and current_pos SHALL increment (dir=1) or decrement (dir=0) in the same cycle.
REQ-028 STEP_HI and STEP_LO SHALL each last exactly HALF_PERIOD cycles; step=0 in STEP_LO.
REQ-029 At end of STEP_LO: current_pos==target -> IDLE; required direction unchanged -> STEP_HI; changed -> update dir, DIR_WAIT.
REQ-030 A target accepted mid-move SHALL take effect only at the next STEP_LO end; a step pulse is never truncated.
REQ-031 trava_servo=1 during a move SHALL let the current STEP_HI/STEP_LO pair finish, then go IDLE keeping the old target.
REQ-032 end_left=1 while dir=0 (not HOMING) SHALL force current_pos=0, step=0, IDLE next cycle, target:=0.
REQ-033 end_right=1 while dir=1 SHALL force current_pos=POS_MAX, step=0, IDLE next cycle, target:=POS_MAX.
REQ-034 current_pos SHALL never wrap below 0 or exceed POS_MAX.

Reset
REQ-035 Reset SHALL force IDLE, step=0, dir=0, current_pos=0, target=0, busy=0, homed=0, timers=0, synchronizers=0, including mid-pulse.

Structure
REQ-036 State encodings and default parameter values SHALL live in shared package equilibrium_pkg.
REQ-037 One sub-module, phase_timer (load/done down-counter), SHALL time DIR_WAIT and the step phases; synchronizer inline.

Verification (bench: HALF_PERIOD=4, DIR_SETUP=2, POS_MAX=200)
REQ-038 Reset, calib, end_left raised after 3 steps -> 3 pulses each 4 high/4 low, then current_pos=0, homed=1, busy=0.
REQ-039 Homed, target 5 -> dir=1, 2-cycle wait, 5 pulses, current_pos 1..5 at each rising step, IDLE after 42 cycles.
REQ-040 At pos 5, target 2 during 2nd step of move to 10 -> step 2 completes at pos 7, dir->0 via 2-cycle wait, 5 pulses to pos 2.
REQ-041 target 300 -> clamps to 200; end_right forced at pos 50 -> current_pos=200, step=0, IDLE next cycle.
REQ-042 trava_servo=1 mid STEP_HI, target_valid pulses ignored -> pulse completes, IDLE, no further steps.
REQ-043 reset asserted during STEP_HI -> step=0, current_pos=0, homed=0 asynchronously.
